// File: rtl/mem_bus_arbiter.sv
// Merges NUM_PORTS single-outstanding request ports onto one shared, variable-latency memory bus.
// Define ARBITER_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (lowest index wins).
module mem_bus_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  localparam int SEL_WIDTH = DATA_WIDTH / 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            port_en,
  input  logic [NUM_PORTS*SEL_WIDTH-1:0]  port_write_en,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] port_write_data,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] port_read_data,
  output logic [NUM_PORTS-1:0]            port_stall,
  output logic                            bus_req,
  output logic [SEL_WIDTH-1:0]            bus_write_en,
  output logic [ADDR_WIDTH-1:0]           bus_addr,
  output logic [DATA_WIDTH-1:0]           bus_write_data,
  input  logic                            bus_ready,
  input  logic [DATA_WIDTH-1:0]           bus_read_data
);
  localparam int GRANT_W = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state_reg;
  logic [GRANT_W-1:0]    grant_reg;
  logic [GRANT_W-1:0]    grant_next;
  logic                  grant_valid;
  logic                  bus_req_reg;
  logic [SEL_WIDTH-1:0]  bus_write_en_reg;
  logic [ADDR_WIDTH-1:0] bus_addr_reg;
  logic [DATA_WIDTH-1:0] bus_write_data_reg;
  logic [DATA_WIDTH-1:0] read_data_reg [NUM_PORTS];
`ifdef ARBITER_ROUND_ROBIN_EN
  localparam logic [GRANT_W:0] NUM_PORTS_W = (GRANT_W + 1)'(NUM_PORTS);
  logic [GRANT_W-1:0]    rr_ptr_reg;
`endif

  // Loops run from the far end so the preferred candidate is assigned last and wins.
  always_comb begin
`ifdef ARBITER_ROUND_ROBIN_EN
    logic [GRANT_W:0] idx;
    idx         = '0;
`endif
    grant_valid = 1'b0;
    grant_next  = '0;
`ifdef ARBITER_ROUND_ROBIN_EN
    for (int k = NUM_PORTS; k >= 1; k--) begin
      idx = {1'b0, rr_ptr_reg} + (GRANT_W + 1)'(k);
      if (idx >= NUM_PORTS_W) idx = idx - NUM_PORTS_W;
      if (port_en[idx[GRANT_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_next  = idx[GRANT_W-1:0];
      end
    end
`else
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (port_en[k]) begin
        grant_valid = 1'b1;
        grant_next  = GRANT_W'(k);
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg          <= IDLE;
      grant_reg          <= '0;
      bus_req_reg        <= 1'b0;
      bus_write_en_reg   <= '0;
      bus_addr_reg       <= '0;
      bus_write_data_reg <= '0;
      for (int i = 0; i < NUM_PORTS; i++) read_data_reg[i] <= '0;
`ifdef ARBITER_ROUND_ROBIN_EN
      rr_ptr_reg         <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            grant_reg          <= grant_next;
            bus_write_en_reg   <= port_write_en[int'(grant_next)*SEL_WIDTH +: SEL_WIDTH];
            bus_addr_reg       <= port_addr[int'(grant_next)*ADDR_WIDTH +: ADDR_WIDTH];
            bus_write_data_reg <= port_write_data[int'(grant_next)*DATA_WIDTH +: DATA_WIDTH];
            bus_req_reg        <= 1'b1;
            state_reg          <= BUSY;
`ifdef ARBITER_ROUND_ROBIN_EN
            rr_ptr_reg         <= grant_next;
`endif
          end
        end
        BUSY: begin
          if (bus_ready) begin
            bus_req_reg <= 1'b0;
            // All-zero strobes mark a read; writes leave the port's read data untouched.
            if (bus_write_en_reg == '0) read_data_reg[grant_reg] <= bus_read_data;
            state_reg <= DONE;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus_req        = bus_req_reg;
  assign bus_write_en   = bus_write_en_reg;
  assign bus_addr       = bus_addr_reg;
  assign bus_write_data = bus_write_data_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign port_stall[gi] = port_en[gi] &
                              ~((state_reg == DONE) && (grant_reg == GRANT_W'(gi)));
      assign port_read_data[gi*DATA_WIDTH +: DATA_WIDTH] = read_data_reg[gi];
    end
  endgenerate

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: a 2-port/32-bit instance with a variable-wait bus model
// and a 4-port/64-bit instance with a zero-wait bus; expected bus transfers are queued and matched.
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  port_en;
  logic [7:0]  port_write_en;
  logic [63:0] port_addr, port_write_data, port_read_data;
  logic [1:0]  port_stall;
  logic        bus_req;
  logic [3:0]  bus_write_en;
  logic [31:0] bus_addr, bus_write_data;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_read_data = '0;

  logic [3:0]   en4;
  logic [31:0]  we4;
  logic [127:0] addr4;
  logic [255:0] wd4, rd4;
  logic [3:0]   stall4;
  logic         req4;
  logic [7:0]   bwe4;
  logic [31:0]  baddr4;
  logic [63:0]  bwd4;
  logic         brdy4 = 1'b0;
  logic [63:0]  brd4 = '0;

  mem_bus_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .port_en(port_en), .port_write_en(port_write_en),
    .port_addr(port_addr), .port_write_data(port_write_data), .port_read_data(port_read_data),
    .port_stall(port_stall), .bus_req(bus_req), .bus_write_en(bus_write_en),
    .bus_addr(bus_addr), .bus_write_data(bus_write_data), .bus_ready(bus_ready),
    .bus_read_data(bus_read_data));

  mem_bus_arbiter #(.NUM_PORTS(4), .ADDR_WIDTH(32), .DATA_WIDTH(64)) dut4 (
    .clk(clk), .rst(rst), .port_en(en4), .port_write_en(we4),
    .port_addr(addr4), .port_write_data(wd4), .port_read_data(rd4),
    .port_stall(stall4), .bus_req(req4), .bus_write_en(bwe4),
    .bus_addr(baddr4), .bus_write_data(bwd4), .bus_ready(brdy4),
    .bus_read_data(brd4));

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wd;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        obs_q[$];
  int          exp_port_q[$];
  int          total = 0;
  int          bad = 0;
  int          wait_cfg = 0;
  int          wait_cnt = 0;
  logic        req_prev = 1'b0;
  int          last_grant = 0;
  int          last_grant4 = 0;
  logic [31:0] exp_rd [2];
  logic [63:0] exp_rd4 [4];

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return (a ^ 32'h5A5A0000) + 32'h00001357;
  endfunction

  // Bus model for the 2-port instance: logs each new transfer and answers after wait_cfg wait cycles.
  always @(posedge clk) begin
    #2;
    if (bus_req && !req_prev) obs_q.push_back('{bus_addr, bus_write_en, bus_write_data});
    req_prev = bus_req;
    if (bus_req && wait_cnt >= wait_cfg) begin
      bus_ready     = 1'b1;
      bus_read_data = rd_model(bus_addr);
      wait_cnt      = 0;
    end else begin
      bus_ready = 1'b0;
      if (bus_req) wait_cnt++;
      else wait_cnt = 0;
    end
  end

  always @(posedge clk) begin
    #2;
    brdy4 = req4;
    brd4  = {baddr4, ~baddr4};
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic set_port(input int p, input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
    port_addr[p*32 +: 32]       = a;
    port_write_en[p*4 +: 4]     = we;
    port_write_data[p*32 +: 32] = wd;
  endtask

  task automatic test_reset();
    rst = 1'b1; port_en = '0; port_write_en = '0; port_addr = '0; port_write_data = '0;
    en4 = '0; we4 = '0; addr4 = '0; wd4 = '0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL reset_bus_req got=%0b want=0", bus_req); end
    total++; if (bus_addr !== 32'h0) begin bad++; $display("FAIL reset_bus_addr got=%h want=0", bus_addr); end
    total++; if (bus_write_en !== 4'h0) begin bad++; $display("FAIL reset_bus_we got=%h want=0", bus_write_en); end
    total++; if (bus_write_data !== 32'h0) begin bad++; $display("FAIL reset_bus_wd got=%h want=0", bus_write_data); end
    total++; if (port_read_data !== 64'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", port_read_data); end
    total++; if (port_stall !== 2'b00) begin bad++; $display("FAIL reset_stall got=%b want=00", port_stall); end
    total++; if (req4 !== 1'b0 || rd4 !== 256'h0) begin bad++; $display("FAIL reset_dut4 req=%0b rd=%h want=0", req4, rd4); end
    exp_rd = '{32'h0, 32'h0};
    for (int p = 0; p < 4; p++) exp_rd4[p] = '0;
    last_grant = 0; last_grant4 = 0;
    @(negedge clk);
    rst = 1'b0;
    $display("txn reset: outputs checked");
  endtask

  task automatic test_single_read();
    int hi = 0;
    bit done = 0;
    @(negedge clk);
    set_port(1, 32'h100, 4'h0, 32'h0);
    port_en[1] = 1'b1;
    exp_q.push_back('{32'h100, 4'h0, 32'h0});
    for (int c = 0; c < 20 && !done; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      if (port_stall[1]) hi++;
      else done = 1;
    end
    exp_rd[1] = 32'hDEADBEEF;
    last_grant = 1;
    total++; if (!done || hi != 2) begin bad++; $display("FAIL single_read_stall high_cycles=%0d done=%0b want=2", hi, done); end
    total++; if (port_read_data[63:32] !== exp_rd[1]) begin bad++; $display("FAIL single_read_data got=%h want=%h", port_read_data[63:32], exp_rd[1]); end
    @(negedge clk);
    port_en[1] = 1'b0;
    $display("txn single_read: port1 addr=100 stall_cycles=%0d data=%h", hi, port_read_data[63:32]);
  endtask

  task automatic test_write_wait();
    int hi = 0;
    int req_cycles = 0;
    bit done = 0;
    wait_cfg = 4;
    @(negedge clk);
    set_port(0, 32'h200, 4'b0011, 32'h12345678);
    port_en[0] = 1'b1;
    exp_q.push_back('{32'h200, 4'b0011, 32'h12345678});
    for (int c = 0; c < 30 && !done; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      if (bus_req) begin
        req_cycles++;
        total++;
        if (bus_addr !== 32'h200 || bus_write_en !== 4'b0011 || bus_write_data !== 32'h12345678) begin
          bad++; $display("FAIL write_bus_stable got=%h/%b/%h want=200/0011/12345678", bus_addr, bus_write_en, bus_write_data);
        end
      end
      if (port_stall[0]) hi++;
      else done = 1;
    end
    last_grant = 0;
    total++; if (!done || hi != 6) begin bad++; $display("FAIL write_stall high_cycles=%0d done=%0b want=6", hi, done); end
    total++; if (req_cycles != 5) begin bad++; $display("FAIL write_req_cycles got=%0d want=5", req_cycles); end
    total++; if (port_read_data[31:0] !== exp_rd[0]) begin bad++; $display("FAIL write_rdata_kept got=%h want=%h", port_read_data[31:0], exp_rd[0]); end
    @(negedge clk);
    port_en[0] = 1'b0;
    wait_cfg = 0;
    $display("txn write_wait: port0 addr=200 stall_cycles=%0d req_cycles=%0d", hi, req_cycles);
  endtask

  task automatic test_arbitration();
    int lg;
    int ncomp = 0;
    int p;
    logic [1:0] want_stall;
    logic [31:0] a;
    @(negedge clk);
    set_port(0, 32'h300, 4'h0, 32'h0);
    set_port(1, 32'h400, 4'h0, 32'h0);
    lg = last_grant;
    for (int k = 0; k < 6; k++) begin
`ifdef ARBITER_ROUND_ROBIN_EN
      p = (lg + 1) % 2;
`else
      p = 0;
`endif
      lg = p;
      exp_port_q.push_back(p);
      exp_q.push_back('{(p == 1) ? 32'h400 : 32'h300, 4'h0, 32'h0});
    end
    port_en = 2'b11;
    for (int c = 0; c < 60 && ncomp < 6; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      if (port_stall != 2'b11) begin
        p = exp_port_q.pop_front();
        a = (p == 1) ? 32'h400 : 32'h300;
        exp_rd[p] = rd_model(a);
        want_stall = 2'b11;
        want_stall[p] = 1'b0;
        ncomp++;
        total++; if (port_stall !== want_stall) begin bad++; $display("FAIL arb_grant_%0d stall=%b want=%b", ncomp, port_stall, want_stall); end
        total++; if (port_read_data[p*32 +: 32] !== exp_rd[p]) begin bad++; $display("FAIL arb_rdata_%0d got=%h want=%h", ncomp, port_read_data[p*32 +: 32], exp_rd[p]); end
        $display("txn arbitration: completion %0d port=%0d stall=%b", ncomp, p, port_stall);
      end
    end
    total++; if (ncomp != 6) begin bad++; $display("FAIL arb_timeout completions=%0d want=6", ncomp); end
    last_grant = lg;
    @(negedge clk);
    port_en = 2'b00;
    exp_port_q.delete();
  endtask

  task automatic test_reset_mid_busy();
    bit seen = 0;
    bit done = 0;
    wait_cfg = 10;
    @(negedge clk);
    set_port(1, 32'h500, 4'h0, 32'h0);
    port_en[1] = 1'b1;
    exp_q.push_back('{32'h500, 4'h0, 32'h0});
    exp_q.push_back('{32'h500, 4'h0, 32'h0});
    for (int c = 0; c < 10 && !seen; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      seen = bus_req;
    end
    total++; if (!seen) begin bad++; $display("FAIL rstbusy_req_timeout got=0 want=1"); end
    @(negedge clk);
    rst = 1'b1;
    wait_cfg = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    exp_rd = '{32'h0, 32'h0};
    last_grant = 0; last_grant4 = 0;
    total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL rstbusy_bus_req got=%0b want=0", bus_req); end
    total++; if (port_read_data !== 64'h0) begin bad++; $display("FAIL rstbusy_rdata got=%h want=0", port_read_data); end
    total++; if (port_stall !== 2'b10) begin bad++; $display("FAIL rstbusy_stall got=%b want=10", port_stall); end
    for (int c = 0; c < 10 && !done; c++) begin
      @(negedge clk);
      #1;
      done = !port_stall[1];
    end
    exp_rd[1] = rd_model(32'h500);
    last_grant = 1;
    total++; if (!done || port_read_data[63:32] !== exp_rd[1]) begin bad++; $display("FAIL rstbusy_regrant done=%0b got=%h want=%h", done, port_read_data[63:32], exp_rd[1]); end
    @(negedge clk);
    port_en[1] = 1'b0;
    $display("txn reset_mid_busy: port1 addr=500 regranted data=%h", port_read_data[63:32]);
  endtask

  task automatic test_drop_en();
    bit seen = 0;
    bit done = 0;
    wait_cfg = 2;
    @(negedge clk);
    set_port(1, 32'h600, 4'h0, 32'h0);
    port_en = 2'b10;
    exp_q.push_back('{32'h600, 4'h0, 32'h0});
    for (int c = 0; c < 10 && !seen; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      seen = bus_req;
    end
    @(negedge clk);
    port_en = 2'b00;
    for (int c = 0; c < 12 && !done; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      total++; if (port_stall !== 2'b00) begin bad++; $display("FAIL drop_stall cycle=%0d got=%b want=00", c, port_stall); end
      done = !bus_req;
    end
    exp_rd[1] = rd_model(32'h600);
    last_grant = 1;
    total++; if (!seen || !done) begin bad++; $display("FAIL drop_timeout seen=%0b done=%0b want=1/1", seen, done); end
    @(negedge clk);
    #1;
    total++; if (port_read_data[63:32] !== exp_rd[1]) begin bad++; $display("FAIL drop_rdata got=%h want=%h", port_read_data[63:32], exp_rd[1]); end
    wait_cfg = 0;
    $display("txn drop_en: port1 addr=600 data=%h", port_read_data[63:32]);
  endtask

  task automatic test_four_ports();
    int lg;
    int p;
    int ncomp = 0;
    int cnt [4] = '{0, 0, 0, 0};
    int want_cnt;
    logic prev_req = 1'b0;
    logic [3:0] want_stall;
    logic [31:0] a;
    @(negedge clk);
    for (int q = 0; q < 4; q++) begin
      addr4[q*32 +: 32] = 32'h1000 + 32'(q) * 32'h10;
      we4[q*8 +: 8]     = (q == 2) ? 8'hF0 : 8'h00;
      wd4[q*64 +: 64]   = 64'hCAFE_0000_0000_0000 + 64'(q);
    end
    lg = last_grant4;
    for (int k = 0; k < 8; k++) begin
`ifdef ARBITER_ROUND_ROBIN_EN
      p = (lg + 1) % 4;
`else
      p = 0;
`endif
      lg = p;
      exp_port_q.push_back(p);
    end
    en4 = 4'hF;
    for (int c = 0; c < 80 && ncomp < 8; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      if (req4 && !prev_req) begin
        p = exp_port_q[0];
        total++;
        if (baddr4 !== addr4[p*32 +: 32] || bwe4 !== we4[p*8 +: 8]) begin
          bad++; $display("FAIL quad_bus got=%h/%h want=%h/%h", baddr4, bwe4, addr4[p*32 +: 32], we4[p*8 +: 8]);
        end
      end
      prev_req = req4;
      if (stall4 != 4'hF) begin
        p = exp_port_q.pop_front();
        a = 32'h1000 + 32'(p) * 32'h10;
        if (p != 2) exp_rd4[p] = {a, ~a};
        want_stall = 4'hF;
        want_stall[p] = 1'b0;
        cnt[p]++;
        ncomp++;
        total++; if (stall4 !== want_stall) begin bad++; $display("FAIL quad_grant_%0d stall=%b want=%b", ncomp, stall4, want_stall); end
        total++; if (rd4[p*64 +: 64] !== exp_rd4[p]) begin bad++; $display("FAIL quad_rdata_%0d got=%h want=%h", ncomp, rd4[p*64 +: 64], exp_rd4[p]); end
        $display("txn four_ports: completion %0d port=%0d stall=%b", ncomp, p, stall4);
      end
    end
    total++; if (ncomp != 8) begin bad++; $display("FAIL quad_timeout completions=%0d want=8", ncomp); end
    for (int q = 0; q < 4; q++) begin
`ifdef ARBITER_ROUND_ROBIN_EN
      want_cnt = 2;
`else
      want_cnt = (q == 0) ? 8 : 0;
`endif
      total++; if (cnt[q] != want_cnt) begin bad++; $display("FAIL quad_count_p%0d got=%0d want=%0d", q, cnt[q], want_cnt); end
    end
    last_grant4 = lg;
    @(negedge clk);
    en4 = 4'h0;
    exp_port_q.delete();
  endtask

  task automatic test_scoreboard_drain();
    txn_t e;
    txn_t o;
    int n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n++;
      total++;
      if (obs_q.size() == 0) begin
        bad++; $display("FAIL sb_txn_%0d missing want addr=%h", n, e.addr);
      end else begin
        o = obs_q.pop_front();
        if (o.addr !== e.addr || o.we !== e.we || o.wd !== e.wd) begin
          bad++; $display("FAIL sb_txn_%0d got=%h/%b/%h want=%h/%b/%h", n, o.addr, o.we, o.wd, e.addr, e.we, e.wd);
        end
        $display("txn bus: %0d addr=%h we=%b wd=%h", n, o.addr, o.we, o.wd);
      end
    end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL sb_extra_txns got=%0d want=0", obs_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_wait();
    test_arbitration();
    test_reset_mid_busy();
    test_drop_en();
    test_four_ports();
    repeat (3) @(negedge clk);
    test_scoreboard_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
